// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default operand width.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_half_subtractor.sv
// Combinational half subtractor; two of these plus an OR make one full-subtract bit slice.
module half_subtractor (
    input  logic a,
    input  logic b,
    output logic diff,
    output logic borrow
);

    assign diff   = a ^ b;
    assign borrow = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Result and done pulse are registered on the cycle spent in DONE, giving a WIDTH+1 latency.
//
// state | meaning
// IDLE  | waiting for start_in; operands captured on start
// RUN   | one bit processed per cycle, WIDTH cycles total
// DONE  | working result is published on the next edge, then back to IDLE
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out,
    output logic             busy_out,
    output logic             done_out
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] work;
    logic             bor;
    logic [CNT_W-1:0] cnt;

    logic hs0_diff;
    logic hs0_borrow;
    logic bit_diff;
    logic hs1_borrow;
    logic bor_next;

    half_subtractor u_hs0 (
        .a      (a_sh[0]),
        .b      (b_sh[0]),
        .diff   (hs0_diff),
        .borrow (hs0_borrow)
    );

    half_subtractor u_hs1 (
        .a      (hs0_diff),
        .b      (bor),
        .diff   (bit_diff),
        .borrow (hs1_borrow)
    );

    assign bor_next = hs0_borrow | hs1_borrow;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_in) state_next = RUN;
            RUN:     if (cnt == LAST_BIT) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy_out = (state == RUN) || (state == DONE);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            work       <= '0;
            bor        <= 1'b0;
            cnt        <= '0;
            diff_out   <= '0;
            borrow_out <= 1'b0;
            done_out   <= 1'b0;
        end else begin
            state    <= state_next;
            done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_in) begin
                        a_sh <= a_in;
                        b_sh <= b_in;
                        bor  <= 1'b0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    work <= {bit_diff, work[WIDTH-1:1]};
                    bor  <= bor_next;
                    cnt  <= cnt + CNT_W'(1);
                end
                DONE: begin
                    diff_out   <= work;
                    borrow_out <= bor;
                    done_out   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk_in = 1'b0;
    logic         rst_in = 1'b1;
    logic         start_in = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic [W-1:0] diff_out;
    logic         borrow_out;
    logic         busy_out;
    logic         done_out;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .start_in   (start_in),
        .a_in       (a_in),
        .b_in       (b_in),
        .diff_out   (diff_out),
        .borrow_out (borrow_out),
        .busy_out   (busy_out),
        .done_out   (done_out)
    );

    always #5 clk_in = ~clk_in;

    // Drive a one-cycle start; returns at the negedge following the capture edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk_in);
        a_in = a;
        b_in = b;
        start_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        start_in = 1'b0;
    endtask

    // Counts edges after the capture edge until done_out is seen (0 on timeout).
    task automatic wait_done(output int lat);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            if (n > 1) @(negedge clk_in);
            if (done_out) begin
                lat = n - 1;
                break;
            end
            @(posedge clk_in);
            if (n == 40) lat = 0;
        end
        if (lat == 0) begin
            @(negedge clk_in);
            if (done_out) lat = 40;
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        checks++; if (diff_out !== 8'd0) begin errors++; $display("FAIL reset_diff got %0d exp 0", diff_out); end
        checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL reset_borrow got %b exp 0", borrow_out); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_out); end
        checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done_out); end
        rst_in = 1'b0;
    endtask

    task automatic test_basic();
        logic [W-1:0] va [4] = '{8'd200, 8'd165, 8'd55,  8'd0};
        logic [W-1:0] vb [4] = '{8'd55,  8'd165, 8'd200, 8'd1};
        logic [W-1:0] vd [4] = '{8'd145, 8'd0,   8'd111, 8'd255};
        logic         vr [4] = '{1'b0,   1'b0,   1'b1,   1'b1};
        int lat;
        for (int i = 0; i < 4; i++) begin
            launch(va[i], vb[i]);
            a_in = ~va[i];
            b_in = ~vb[i];
            checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL basic%0d_busy got %b exp 1", i, busy_out); end
            wait_done(lat);
            checks++; if (lat != W + 1) begin errors++; $display("FAIL basic%0d_latency got %0d exp %0d", i, lat, W + 1); end
            checks++; if (diff_out !== vd[i]) begin errors++; $display("FAIL basic%0d_diff got %0d exp %0d", i, diff_out, vd[i]); end
            checks++; if (borrow_out !== vr[i]) begin errors++; $display("FAIL basic%0d_borrow got %b exp %b", i, borrow_out, vr[i]); end
            @(negedge clk_in);
            checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL basic%0d_done_width got %b exp 0", i, done_out); end
        end
    endtask

    task automatic test_ignore_start();
        int pulses = 0;
        int first = 0;
        logic [W-1:0] d_seen = '0;
        logic         b_seen = 1'b1;
        launch(8'd10, 8'd3);
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            if (n == 3) begin start_in = 1'b1; a_in = 8'd1; b_in = 8'd2; end
            if (n == 4) start_in = 1'b0;
            if (n == 5) begin
                checks++; if (diff_out !== 8'd255) begin errors++; $display("FAIL ignore_hold_diff got %0d exp 255", diff_out); end
            end
            if (done_out) begin
                pulses++;
                if (first == 0) begin first = n; d_seen = diff_out; b_seen = borrow_out; end
            end
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL ignore_pulses got %0d exp 1", pulses); end
        checks++; if (first != W + 1) begin errors++; $display("FAIL ignore_latency got %0d exp %0d", first, W + 1); end
        checks++; if (d_seen !== 8'd7) begin errors++; $display("FAIL ignore_diff got %0d exp 7", d_seen); end
        checks++; if (b_seen !== 1'b0) begin errors++; $display("FAIL ignore_borrow got %b exp 0", b_seen); end
    endtask

    task automatic test_reset_abort();
        int lat;
        launch(8'd100, 8'd50);
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk_in);
            @(negedge clk_in);
        end
        rst_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        checks++; if (diff_out !== 8'd0) begin errors++; $display("FAIL abort_diff got %0d exp 0", diff_out); end
        checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL abort_borrow got %b exp 0", borrow_out); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy_out); end
        checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL abort_done got %b exp 0", done_out); end
        rst_in = 1'b0;
        a_in = 8'd9;
        b_in = 8'd4;
        start_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        start_in = 1'b0;
        checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL abort_restart_busy got %b exp 1", busy_out); end
        wait_done(lat);
        checks++; if (lat != W + 1) begin errors++; $display("FAIL abort_restart_latency got %0d exp %0d", lat, W + 1); end
        checks++; if (diff_out !== 8'd5) begin errors++; $display("FAIL abort_restart_diff got %0d exp 5", diff_out); end
        checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL abort_restart_borrow got %b exp 0", borrow_out); end
    endtask

    task automatic test_back_to_back();
        int t [2] = '{0, 0};
        logic [W-1:0] d [2] = '{8'd0, 8'd0};
        logic         r [2] = '{1'b0, 1'b1};
        int pulses = 0;
        @(negedge clk_in);
        a_in = 8'd7;
        b_in = 8'd9;
        start_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        a_in = 8'd9;
        b_in = 8'd7;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            if (n == W + 2) begin
                start_in = 1'b0;
                checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL b2b_second_busy got %b exp 1", busy_out); end
            end
            if (done_out) begin
                if (pulses < 2) begin t[pulses] = n; d[pulses] = diff_out; r[pulses] = borrow_out; end
                pulses++;
            end
        end
        checks++; if (pulses != 2) begin errors++; $display("FAIL b2b_pulses got %0d exp 2", pulses); end
        checks++; if (t[0] != W + 1) begin errors++; $display("FAIL b2b_first_latency got %0d exp %0d", t[0], W + 1); end
        checks++; if (d[0] !== 8'd254) begin errors++; $display("FAIL b2b_first_diff got %0d exp 254", d[0]); end
        checks++; if (r[0] !== 1'b1) begin errors++; $display("FAIL b2b_first_borrow got %b exp 1", r[0]); end
        checks++; if (t[1] - t[0] != W + 2) begin errors++; $display("FAIL b2b_spacing got %0d exp %0d", t[1] - t[0], W + 2); end
        checks++; if (d[1] !== 8'd2) begin errors++; $display("FAIL b2b_second_diff got %0d exp 2", d[1]); end
        checks++; if (r[1] !== 1'b0) begin errors++; $display("FAIL b2b_second_borrow got %b exp 0", r[1]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
